// File: rtl/maxnet_fixed_n.sv
// maxnet_fixed_n: fixed-point Maxnet winner-take-all engine over N channels.
// Activations are updated one channel per cycle against a sum frozen for the
// whole pass, so every channel sees the previous iteration's values (Jacobi).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; results of the last run are held
// S_SUM   | capture the sum of all activations for this iteration
// S_UPD   | update channel r_k, one channel per cycle
// S_CHECK | count survivors, decide finish / timeout / next iteration
// S_DONE  | one-cycle finish pulse, results valid
module maxnet_fixed_n #(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int MAX_ITER = 64,
  parameter int IW       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   eps,
  input  logic        [N*WIDTH-1:0] a_flat,
  output logic                      busy,
  output logic                      finish,
  output logic                      win_valid,
  output logic [$clog2(N)-1:0]      winner_idx,
  output logic signed [WIDTH-1:0]   out,
  output logic [IW-1:0]             iter_count,
  output logic                      timeout
);

  localparam int IDXW = $clog2(N);
  localparam int SW   = WIDTH + $clog2(N);
  localparam int PW   = WIDTH + SW;
  localparam int CW   = $clog2(N + 1);

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_UPD, S_CHECK, S_DONE} state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_eps;
  logic signed [WIDTH-1:0] r_orig [N];
  logic signed [WIDTH-1:0] r_a    [N];
  logic signed [SW-1:0]    r_sum;
  logic [IDXW-1:0]         r_k;

  logic signed [SW-1:0]    w_sum;
  logic signed [WIDTH-1:0] w_a_k;
  logic signed [SW-1:0]    w_d;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_shift;
  logic signed [PW:0]      w_v;
  logic signed [WIDTH-1:0] w_new;
  logic [CW-1:0]           w_nz;
  logic [IDXW-1:0]         w_best_idx;
  logic signed [WIDTH-1:0] w_best_val;
  logic [IW-1:0]           w_iter_next;

  // Sum of all activations; activations are never negative so the extra bits only carry growth.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++)
      w_sum = w_sum + {{(SW-WIDTH){r_a[i][WIDTH-1]}}, r_a[i]};
  end

  // Channel update: a + floor(eps*(S-a) / 2^FRAC), saturated high and clamped at zero.
  always_comb begin
    w_a_k   = r_a[r_k];
    w_d     = r_sum - {{(SW-WIDTH){w_a_k[WIDTH-1]}}, w_a_k};
    w_prod  = $signed({{SW{r_eps[WIDTH-1]}}, r_eps}) * $signed({{WIDTH{w_d[SW-1]}}, w_d});
    w_shift = w_prod >>> FRAC;
    w_v     = $signed({{(PW+1-WIDTH){w_a_k[WIDTH-1]}}, w_a_k}) + $signed({w_shift[PW-1], w_shift});
    if (w_v[PW])
      w_new = '0;
    else if (|w_v[PW-1:WIDTH-1])
      w_new = {1'b0, {(WIDTH-1){1'b1}}};
    else
      w_new = w_v[WIDTH-1:0];
  end

  // Survivor count and largest activation (lowest index wins ties); with a single
  // survivor the largest activation is that survivor.
  always_comb begin
    w_nz       = '0;
    w_best_idx = '0;
    w_best_val = r_a[0];
    for (int i = 0; i < N; i++)
      if (r_a[i] != '0) w_nz = w_nz + CW'(1);
    for (int i = 1; i < N; i++)
      if (r_a[i] > w_best_val) begin
        w_best_val = r_a[i];
        w_best_idx = IDXW'(i);
      end
    w_iter_next = iter_count + IW'(1);
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_eps      <= '0;
      r_sum      <= '0;
      r_k        <= '0;
      for (int i = 0; i < N; i++) begin
        r_orig[i] <= '0;
        r_a[i]    <= '0;
      end
      busy       <= 1'b0;
      finish     <= 1'b0;
      win_valid  <= 1'b0;
      winner_idx <= '0;
      out        <= '0;
      iter_count <= '0;
      timeout    <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_eps <= eps;
            for (int i = 0; i < N; i++) begin
              r_orig[i] <= a_flat[i*WIDTH +: WIDTH];
              r_a[i]    <= a_flat[i*WIDTH + WIDTH - 1] ? '0 : a_flat[i*WIDTH +: WIDTH];
            end
            iter_count <= '0;
            busy       <= 1'b1;
            timeout    <= 1'b0;
            win_valid  <= 1'b0;
            r_state    <= S_SUM;
          end
        end
        S_SUM: begin
          r_sum   <= w_sum;
          r_k     <= '0;
          r_state <= S_UPD;
        end
        S_UPD: begin
          r_a[r_k] <= w_new;
          if (r_k == IDXW'(N-1))
            r_state <= S_CHECK;
          else
            r_k <= r_k + IDXW'(1);
        end
        S_CHECK: begin
          iter_count <= w_iter_next;
          if (w_nz <= CW'(1)) begin
            finish  <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
            if (w_nz == CW'(1)) begin
              win_valid  <= 1'b1;
              winner_idx <= w_best_idx;
              out        <= r_orig[w_best_idx];
            end else begin
              win_valid  <= 1'b0;
              winner_idx <= '0;
              out        <= '0;
            end
          end else if (w_iter_next == IW'(MAX_ITER)) begin
            finish     <= 1'b1;
            busy       <= 1'b0;
            timeout    <= 1'b1;
            win_valid  <= 1'b1;
            winner_idx <= w_best_idx;
            out        <= r_orig[w_best_idx];
            r_state    <= S_DONE;
          end else begin
            r_state <= S_SUM;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_fixed_n.sv
// Bench for maxnet_fixed_n: directed scenarios plus randomized runs against an
// iteration-level arithmetic model. Two instances share inputs: MAX_ITER 64 and 8.
module tb_maxnet_fixed_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        start64, start8;
  logic [15:0] eps;
  logic [63:0] a_flat;

  logic        busy64, fin64, wv64, to64;
  logic [1:0]  idx64;
  logic [15:0] out64;
  logic [7:0]  it64;
  logic        busy8, fin8, wv8, to8;
  logic [1:0]  idx8;
  logic [15:0] out8;
  logic [7:0]  it8;

  int checks;
  int failures;

  localparam logic [63:0] S1  = {16'h014D, 16'h0000, 16'h9C00, 16'h6400};
  localparam logic [63:0] TIE = {16'h0000, 16'h0000, 16'h3200, 16'h3200};
  localparam logic [63:0] SAT = {16'h0000, 16'h0000, 16'h7F00, 16'h7FFF};

  typedef struct {
    logic        got;
    int          cyc;
    logic        busy0;
    logic        busy_fin;
    logic        wv;
    logic [1:0]  idx;
    logic [15:0] out;
    logic [7:0]  iter;
    logic        to;
  } obs_t;

  always #5 clk = ~clk;

  maxnet_fixed_n #(.N(4), .WIDTH(16), .FRAC(8), .MAX_ITER(64), .IW(8)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .eps(eps), .a_flat(a_flat),
    .busy(busy64), .finish(fin64), .win_valid(wv64), .winner_idx(idx64),
    .out(out64), .iter_count(it64), .timeout(to64));

  maxnet_fixed_n #(.N(4), .WIDTH(16), .FRAC(8), .MAX_ITER(8), .IW(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .eps(eps), .a_flat(a_flat),
    .busy(busy8), .finish(fin8), .win_valid(wv8), .winner_idx(idx8),
    .out(out8), .iter_count(it8), .timeout(to8));

  function automatic longint floor_div(input longint p, input longint q);
    longint r;
    r = p / q;
    if ((p % q != 0) && (p < 0)) r = r - 1;
    return r;
  endfunction

  // Whole-iteration reference: all channels computed from the previous vector.
  task automatic ref_model(input logic [63:0] af, input logic [15:0] e, input int max_it,
                           output int ex_iter, output logic ex_to, output logic ex_wv,
                           output logic [1:0] ex_idx, output logic [15:0] ex_out);
    longint a[4], nw[4], s, v, ee;
    logic signed [15:0] t;
    int nz, best;
    t  = e;
    ee = t;
    for (int i = 0; i < 4; i++) begin
      t    = af[i*16 +: 16];
      a[i] = (t < 0) ? 0 : t;
    end
    ex_iter = 0;
    do begin
      s = a[0] + a[1] + a[2] + a[3];
      for (int i = 0; i < 4; i++) begin
        v = a[i] + floor_div(ee * (s - a[i]), 256);
        if (v > 32767) v = 32767;
        if (v < 0) v = 0;
        nw[i] = v;
      end
      nz = 0;
      for (int i = 0; i < 4; i++) begin
        a[i] = nw[i];
        if (a[i] != 0) nz++;
      end
      ex_iter++;
    end while (nz > 1 && ex_iter < max_it);
    ex_to = (nz > 1);
    best = 0;
    for (int i = 1; i < 4; i++) if (a[i] > a[best]) best = i;
    if (nz == 0) begin
      ex_wv = 1'b0; ex_idx = 2'd0; ex_out = 16'h0000;
    end else begin
      ex_wv = 1'b1; ex_idx = 2'(best); ex_out = af[best*16 +: 16];
    end
  endtask

  // Stimulus only: start one run on the chosen instance and capture what it reports.
  task automatic drive(input logic [63:0] af, input logic [15:0] e, input bit use8, output obs_t o);
    logic f;
    a_flat = af;
    eps    = e;
    repeat (2) @(negedge clk);
    if (use8) start8 = 1'b1; else start64 = 1'b1;
    @(posedge clk); #1;
    start8  = 1'b0;
    start64 = 1'b0;
    o.busy0 = use8 ? busy8 : busy64;
    o.got   = 1'b0;
    o.cyc   = 0;
    while (o.got !== 1'b1 && o.cyc < 2000) begin
      @(posedge clk); o.cyc++; #1;
      f = use8 ? fin8 : fin64;
      if (f === 1'b1) o.got = 1'b1;
    end
    o.busy_fin = use8 ? busy8 : busy64;
    o.wv       = use8 ? wv8   : wv64;
    o.idx      = use8 ? idx8  : idx64;
    o.out      = use8 ? out8  : out64;
    o.iter     = use8 ? it8   : it64;
    o.to       = use8 ? to8   : to64;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy64, fin64, wv64, idx64, out64, it64, to64} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs_64 got=%h exp=0", {busy64, fin64, wv64, idx64, out64, it64, to64});
    end
    checks++;
    if ({busy8, fin8, wv8, idx8, out8, it8, to8} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs_8 got=%h exp=0", {busy8, fin8, wv8, idx8, out8, it8, to8});
    end
    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++;
    if ({busy64, fin64} !== 2'b00) begin
      failures++;
      $display("FAIL idle_without_start got=%b exp=00", {busy64, fin64});
    end
  endtask

  task automatic test_scenario1();
    obs_t o;
    drive(S1, 16'hFFCD, 1'b0, o);
    checks++; if (o.busy0 !== 1'b1) begin failures++; $display("FAIL s1_busy_after_start got=%b exp=1", o.busy0); end
    checks++; if (o.got !== 1'b1 || o.cyc != 6) begin failures++; $display("FAIL s1_latency got=%0d exp=6", o.cyc); end
    checks++; if (o.busy_fin !== 1'b0) begin failures++; $display("FAIL s1_busy_at_finish got=%b exp=0", o.busy_fin); end
    checks++; if ({o.wv, o.idx, o.to} !== 4'b1_00_0) begin failures++; $display("FAIL s1_wv_idx_to got=%b%b%b exp=1000", o.wv, o.idx, o.to); end
    checks++; if (o.out !== 16'h6400) begin failures++; $display("FAIL s1_out got=%h exp=6400", o.out); end
    checks++; if (o.iter !== 8'd1) begin failures++; $display("FAIL s1_iter got=%0d exp=1", o.iter); end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({fin64, busy64, wv64, idx64, out64, it64} !== {1'b0, 1'b0, 1'b1, 2'd0, 16'h6400, 8'd1}) begin
      failures++;
      $display("FAIL s1_hold got=%b%b%b %0d %h %0d exp=001 0 6400 1", fin64, busy64, wv64, idx64, out64, it64);
    end
  endtask

  task automatic test_all_zero();
    obs_t o;
    drive(64'd0, 16'hFFCD, 1'b0, o);
    checks++; if (o.got !== 1'b1 || o.cyc != 6) begin failures++; $display("FAIL zero_latency got=%0d exp=6", o.cyc); end
    checks++; if ({o.wv, o.idx, o.out, o.to} !== 20'd0) begin failures++; $display("FAIL zero_result got=%b %0d %h %b exp=0 0 0000 0", o.wv, o.idx, o.out, o.to); end
    checks++; if (o.iter !== 8'd1) begin failures++; $display("FAIL zero_iter got=%0d exp=1", o.iter); end
  endtask

  task automatic test_tie();
    obs_t o;
    drive(TIE, 16'hFF80, 1'b0, o);
    checks++; if (o.got !== 1'b1 || o.cyc != 84) begin failures++; $display("FAIL tie_latency got=%0d exp=84", o.cyc); end
    checks++; if ({o.wv, o.to, o.out} !== 18'd0) begin failures++; $display("FAIL tie_result got=%b %b %h exp=0 0 0000", o.wv, o.to, o.out); end
    checks++; if (o.iter !== 8'd14) begin failures++; $display("FAIL tie_iter got=%0d exp=14", o.iter); end
  endtask

  task automatic test_tie_timeout();
    obs_t o;
    drive(TIE, 16'hFF80, 1'b1, o);
    checks++; if (o.got !== 1'b1 || o.cyc != 48) begin failures++; $display("FAIL tie8_latency got=%0d exp=48", o.cyc); end
    checks++; if ({o.to, o.wv, o.idx} !== 4'b11_00) begin failures++; $display("FAIL tie8_flags got=%b%b idx=%0d exp=11 idx=0", o.to, o.wv, o.idx); end
    checks++; if (o.out !== 16'h3200) begin failures++; $display("FAIL tie8_out got=%h exp=3200", o.out); end
    checks++; if (o.iter !== 8'd8) begin failures++; $display("FAIL tie8_iter got=%0d exp=8", o.iter); end
  endtask

  task automatic test_saturation();
    obs_t o;
    drive(SAT, 16'h0100, 1'b0, o);
    checks++; if (o.got !== 1'b1 || o.cyc != 384) begin failures++; $display("FAIL sat_latency got=%0d exp=384", o.cyc); end
    checks++; if ({o.to, o.wv, o.idx} !== 4'b11_00) begin failures++; $display("FAIL sat_flags got=%b%b idx=%0d exp=11 idx=0", o.to, o.wv, o.idx); end
    checks++; if (o.out !== 16'h7FFF || o.iter !== 8'd64) begin failures++; $display("FAIL sat_out_iter got=%h %0d exp=7fff 64", o.out, o.iter); end
  endtask

  task automatic test_restart_ignored();
    int cyc;
    bit got;
    bit extra;
    a_flat = S1;
    eps    = 16'hFFCD;
    repeat (2) @(negedge clk);
    start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    repeat (2) @(posedge clk); #1;
    start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    cyc = 3;
    got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (fin64 === 1'b1) got = 1;
    end
    checks++; if (!got || cyc != 6) begin failures++; $display("FAIL restart_latency got=%0d exp=6", cyc); end
    checks++;
    if ({wv64, idx64, out64, it64, to64} !== {1'b1, 2'd0, 16'h6400, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL restart_result got=%b %0d %h %0d %b exp=1 0 6400 1 0", wv64, idx64, out64, it64, to64);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy64 !== 1'b0 || fin64 !== 1'b0) extra = 1;
    end
    checks++; if (extra) begin failures++; $display("FAIL restart_second_run got=activity exp=idle"); end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    bit seen;
    a_flat = S1;
    eps    = 16'hFFCD;
    repeat (2) @(negedge clk);
    start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (busy64 !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b exp=1", busy64); end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy64, fin64, wv64, idx64, out64, it64, to64} !== 30'd0) begin
      failures++;
      $display("FAIL midrun_async_clear got=%h exp=0", {busy64, fin64, wv64, idx64, out64, it64, to64});
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (fin64 !== 1'b0 || busy64 !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midrun_no_finish got=activity exp=idle"); end
    drive(S1, 16'hFFCD, 1'b0, o);
    checks++;
    if (o.got !== 1'b1 || o.cyc != 6 || {o.wv, o.idx, o.out, o.iter, o.to} !== {1'b1, 2'd0, 16'h6400, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL midrun_rerun got=cyc%0d %b %0d %h %0d %b exp=cyc6 1 0 6400 1 0", o.cyc, o.wv, o.idx, o.out, o.iter, o.to);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [63:0] af;
    logic [15:0] e;
    bit          u8;
    int          ei;
    logic        eto, ewv;
    logic [1:0]  eidx;
    logic [15:0] eout;
    for (int n = 0; n < 40; n++) begin
      af = {$urandom(), $urandom()};
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) af[k*16 +: 16] = 16'h0000;
      if ($urandom_range(0, 2) == 0) e = 16'(-$urandom_range(1, 12));
      else                           e = 16'(-$urandom_range(13, 300));
      u8 = (n % 2) == 1;
      ref_model(af, e, u8 ? 8 : 64, ei, eto, ewv, eidx, eout);
      drive(af, e, u8, o);
      checks++;
      if (o.got !== 1'b1 || o.cyc != 6 * ei) begin
        failures++;
        $display("FAIL rnd%0d_latency got=%0d exp=%0d a=%h eps=%h", n, o.cyc, 6 * ei, af, e);
      end
      checks++;
      if ({o.wv, o.to, o.iter} !== {ewv, eto, 8'(ei)}) begin
        failures++;
        $display("FAIL rnd%0d_flags got=wv%b to%b it%0d exp=wv%b to%b it%0d a=%h eps=%h", n, o.wv, o.to, o.iter, ewv, eto, ei, af, e);
      end
      checks++;
      if ({o.idx, o.out} !== {eidx, eout}) begin
        failures++;
        $display("FAIL rnd%0d_winner got=%0d/%h exp=%0d/%h a=%h eps=%h", n, o.idx, o.out, eidx, eout, af, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start64  = 1'b0;
    start8   = 1'b0;
    a_flat   = '0;
    eps      = '0;
    test_reset();
    test_scenario1();
    test_all_zero();
    test_tie();
    test_tie_timeout();
    test_saturation();
    test_restart_ignored();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxnet_fixed_n.md
Name: maxnet_fixed_n

Overview:
- Parametrised fixed-point Maxnet winner-take-all engine for N channels.
- Replaces the fixed 4-input float model.
- On start, latches N signed inputs and a negative inhibition weight eps, then iterates a_i <= relu(a_i + eps*sum_{j!=i} a_j) until at most one channel is nonzero.
- Reports winner index, the winner's original input value, iteration count and a timeout flag.

Parameters:
- N, 4, channel count (>=2)
- WIDTH, 16, signed data width of each input, eps and out
- FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC)
- MAX_ITER, 64, iteration limit before forced termination
- IW, 8, width of iter_count (must hold MAX_ITER)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- eps  in  WIDTH  signed inhibition weight, expected negative
- a_flat  in  N*WIDTH  inputs, channel k at bits [k*WIDTH +: WIDTH]
- busy  out  1  high from accepted start until finish
- finish  out  1  one-cycle pulse, results valid
- win_valid  out  1  1 if exactly one channel survived or timeout
- winner_idx  out  clog2(N)  winning channel
- out  out  WIDTH  original (pre-clamp) input of winner
- iter_count  out  IW  iterations executed
- timeout  out  1  terminated by MAX_ITER

Behaviour:
- Reset (rst=0, any time, including mid-run): state IDLE; all outputs 0; internal registers 0. Operation resumes only on a new start after release.
- States: IDLE, SUM, UPD, CHECK, DONE.
- IDLE, start=1:
  - Latch eps, originals orig[k]; a[k] = max(orig[k], 0).
  - Clear iter counter; busy=1; go to SUM.
  - start in any other state is ignored.
- SUM (1 cycle): S <= sum of all a[k], width WIDTH+clog2(N), signed; go to UPD, k=0.
- UPD (N cycles, one channel per cycle, k=0..N-1):
  - d = S - a[k]; p = eps*d at full precision; p arithmetic-shifted right by FRAC (floor).
  - v = a[k] + p; saturate to WIDTH signed; clamp negative to 0; write a[k].
  - S is frozen for the whole pass, giving a synchronous (Jacobi) update.
  - After k=N-1, go to CHECK.
- CHECK (1 cycle):
  - iter+1; nz = count of a[k] != 0.
  - nz<=1: DONE.
  - Else if iter+1 == MAX_ITER: DONE with timeout=1.
  - Else: SUM.
- DONE (1 cycle):
  - finish=1, busy=0.
  - nz==1: win_valid=1, winner_idx = the nonzero channel, out = orig[winner].
  - nz==0 (ties annihilated or all-zero input): win_valid=0, winner_idx=0, out=0.
  - Timeout: win_valid=1; winner = largest a[k], lowest index on ties; out = orig of that channel.
  - Go to IDLE.
- Results hold stable until the next accepted start, which clears timeout/win_valid.
- Latency: finish is high in the cycle following edge (N+2)*K after the start-sampling edge, K = iterations executed.
- No early-out before the first iteration: K >= 1 always.

Test Plan:
1. N=4, WIDTH=16, FRAC=8; eps=0xFFCD (-51/256); a={0x6400, 0x9C00(-100), 0x0000, 0x014D}, start pulse → iteration 1 gives S=25933, a0=25533, a3=0 → finish at edge 6 after start; win_valid=1, winner_idx=0, out=0x6400, iter_count=1, timeout=0.
2. All inputs 0, eps=0xFFCD → finish after 6 cycles; win_valid=0, out=0, iter_count=1.
3. Tie: a0=a1=0x3200 (50.0), others 0, eps=0xFF80 (-0.5), MAX_ITER=64 → both channels halve (floor) each iteration and reach 0 together; finish with win_valid=0, iter_count=14, timeout=0.
4. Same stimulus as 3 on an instance with MAX_ITER=8 → timeout=1, win_valid=1, winner_idx=0, out=0x3200, iter_count=8, finish 48 cycles after start.
5. Start re-asserted during UPD of scenario 1 → ignored; results identical to scenario 1. rst low for 1 cycle mid-UPD → all outputs 0 immediately (asynchronous), no finish; a subsequent start reproduces scenario 1 exactly.
6. Saturation: a0=0x7FFF, a1=0x7F00, eps=0x0100 (+1.0, misuse) → updates saturate at 0x7FFF without wrap; terminates by timeout at MAX_ITER with winner_idx=0.
